alu_pipe: RTL

Parametrised, handshaked successor to the combinational 16-bit ALU. It executes the same ten opcodes at any byte-multiple width and registers every result behind a valid/ready output. It adds a multi-cycle shift-add multiply and a Z/V/N flag register for branch logic. It sits between the decode/issue stage and writeback, and it stalls issue through `in_ready`.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_seq.sv | 39 +++
 rtl/alu_pipe.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag indices, FSM states and the saturating nibble adder shared by alu_pipe
package alu_pkg;
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LLB    = 4'h8;
  localparam logic [3:0] OP_LHB    = 4'h9;
  localparam logic [3:0] OP_MUL    = 4'hA;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  function automatic logic [3:0] sat4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {a[3], a} + {b[3], b};
    return (s[4] != s[3]) ? (s[4] ? 4'h8 : 4'h7) : s[3:0];
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one partial product per cycle, low WIDTH bits kept
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] ma, mb;
  logic [CW-1:0] cnt;
  logic busy;
  assign done = busy && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      ma   <= '0;
      mb   <= '0;
      p    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      ma   <= a;
      mb   <= b;
      p    <= '0;
    end else if (busy) begin
      p    <= p + (mb[0] ? ma : '0);
      ma   <= ma << 1;
      mb   <= mb >> 1;
      cnt  <= cnt + CW'(1);
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU with saturating arithmetic, sequential multiply and Z/V/N flags
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             err,
  output logic [2:0]       flags
);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW:0] WL = (SHW+1)'(WIDTH);
  state_t state;
  logic [SHW-1:0] sh;
  logic [WIDTH-1:0] sum, dif, sra, ror, red, pad, res, prod;
  logic ov_add, ov_sub, ov, rerr, z_en, vn_en, free, fire, mdone;
  assign sh     = aluin2[SHW-1:0];
  assign sum    = aluin1 + aluin2;
  assign dif    = aluin1 - aluin2;
  assign ov_add = aluin1[WIDTH-1] == aluin2[WIDTH-1] && sum[WIDTH-1] != aluin1[WIDTH-1];
  assign ov_sub = aluin1[WIDTH-1] != aluin2[WIDTH-1] && dif[WIDTH-1] != aluin1[WIDTH-1];
  assign sra    = $signed(aluin1) >>> sh;
  assign ror    = (aluin1 >> sh) | (aluin1 << (WL - {1'b0, sh}));
  assign free     = !out_valid || out_ready;
  assign in_ready = state == S_IDLE && free && !rst;
  assign fire     = in_valid && in_ready;
  always_comb begin
    red = '0;
    pad = '0;
    for (int i = 0; i < WIDTH / 8; i++)
      red = red + WIDTH'(aluin1[8*i +: 8]) + WIDTH'(aluin2[8*i +: 8]);
    for (int i = 0; i < WIDTH / 4; i++)
      pad[4*i +: 4] = sat4(aluin1[4*i +: 4], aluin2[4*i +: 4]);
  end
  always_comb begin
    res   = '0;
    rerr  = 1'b0;
    ov    = 1'b0;
    z_en  = 1'b1;
    vn_en = 1'b0;
    case (aluop)
      OP_ADD: begin
        ov    = ov_add;
        res   = ov_add ? (aluin1[WIDTH-1] ? SMIN : SMAX) : sum;
        rerr  = ov_add;
        vn_en = 1'b1;
      end
      OP_SUB: begin
        ov    = ov_sub;
        res   = ov_sub ? (aluin1[WIDTH-1] ? SMIN : SMAX) : dif;
        rerr  = ov_sub;
        vn_en = 1'b1;
      end
      OP_XOR:    res = aluin1 ^ aluin2;
      OP_RED:    res = red;
      OP_SLL:    res = aluin1 << sh;
      OP_SRA:    res = sra;
      OP_ROR:    res = ror;
      OP_PADDSB: res = pad;
      OP_LLB: begin
        res  = {aluin1[WIDTH-1:8], aluin2[7:0]};
        z_en = 1'b0;
      end
      OP_LHB: begin
        res  = {aluin2[7:0], aluin1[WIDTH-9:0]};
        z_en = 1'b0;
      end
      OP_MUL: ;
      default: begin
        rerr = 1'b1;
        z_en = 1'b0;
      end
    endcase
  end
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(fire && aluop == OP_MUL),
    .a    (aluin1),
    .b    (aluin2),
    .done (mdone),
    .p    (prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      aluout    <= '0;
      err       <= 1'b0;
      flags     <= '0;
    end else begin
      out_valid <= out_valid && !out_ready;
      if (fire && aluop != OP_MUL) begin
        out_valid <= 1'b1;
        aluout    <= res;
        err       <= rerr;
        if (z_en) flags[FLG_Z] <= res == '0;
        if (vn_en) begin
          flags[FLG_V] <= ov;
          flags[FLG_N] <= res[WIDTH-1];
        end
      end
      if (fire && aluop == OP_MUL) state <= S_BUSY;
      if (state == S_BUSY && mdone) state <= S_DONE;
      if (state == S_DONE && free) begin
        out_valid     <= 1'b1;
        aluout        <= prod;
        err           <= 1'b0;
        flags[FLG_Z]  <= prod == '0;
        state         <= S_IDLE;
      end
    end
  end
endmodule
